lstm_seq_ctrl: RTL

//  Sequencer that drives the lstm_cell start/done interface over a sequence of timesteps.

---
 rtl/lstm_seq_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: steps an lstm_cell through a sequence of timesteps.
// Accepts one x vector per step, fires the cell, captures h/c into the
// recurrent state registers and streams every resulting h vector out.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A producer holds valid and its data stable until that edge.
// The controller raises x_ready only in LOAD and h_out_valid only in EMIT.
// Both are decoded from the state register alone, so neither depends
// combinationally on the partner's valid or ready.
module lstm_seq_ctrl #(
    parameter int INPUT_SIZE  = 6,
    parameter int HIDDEN_SIZE = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int LEN_W       = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              seq_start,
    input  logic [LEN_W-1:0]                  seq_len,
    output logic                              busy,
    output logic                              seq_done,
    output logic                              error,
    input  logic                              x_valid,
    output logic                              x_ready,
    input  logic [DATA_WIDTH*INPUT_SIZE-1:0]  x_in,
    output logic                              cell_start,
    input  logic                              cell_done,
    output logic [DATA_WIDTH*INPUT_SIZE-1:0]  cell_x,
    output logic [DATA_WIDTH*HIDDEN_SIZE-1:0] cell_h_prev,
    output logic [DATA_WIDTH*HIDDEN_SIZE-1:0] cell_c_prev,
    input  logic [DATA_WIDTH*HIDDEN_SIZE-1:0] cell_h,
    input  logic [DATA_WIDTH*HIDDEN_SIZE-1:0] cell_c,
    output logic                              h_out_valid,
    input  logic                              h_out_ready,
    output logic [DATA_WIDTH*HIDDEN_SIZE-1:0] h_out
);

    localparam int XW  = DATA_WIDTH * INPUT_SIZE;
    localparam int HW  = DATA_WIDTH * HIDDEN_SIZE;
    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_FIRE = 3'd2,
        S_WAIT = 3'd3,
        S_EMIT = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    // state is the single observable FSM register for checkers and waveforms
    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] remaining;
    logic [TCW-1:0]   tcnt;
    logic [XW-1:0]    x_reg;
    logic [HW-1:0]    h_reg;
    logic [HW-1:0]    c_reg;
    logic             err_reg;
    logic             timed_out;

    // Last permitted WAIT cycle without a done
    assign timed_out = (tcnt == TCW'(TIMEOUT - 1));

    // State register; async reset drops any in-flight step back to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and Moore outputs decoded from the current state
    always_comb begin
        state_nxt   = state;
        busy        = 1'b1;
        seq_done    = 1'b0;
        x_ready     = 1'b0;
        cell_start  = 1'b0;
        h_out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (seq_start) begin
                    state_nxt = (seq_len == '0) ? S_FIN : S_LOAD;
                end
            end
            S_LOAD: begin
                x_ready = 1'b1;
                if (x_valid) begin
                    state_nxt = S_FIRE;
                end
            end
            S_FIRE: begin
                cell_start = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                // done wins over timeout if both land on the same cycle
                if (cell_done) begin
                    state_nxt = S_EMIT;
                end else if (timed_out) begin
                    state_nxt = S_FIN;
                end
            end
            S_EMIT: begin
                h_out_valid = 1'b1;
                if (h_out_ready) begin
                    state_nxt = (remaining != '0) ? S_LOAD : S_FIN;
                end
            end
            S_FIN: begin
                seq_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: step counter, timeout counter, x capture, recurrent h/c state, error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            tcnt      <= '0;
            x_reg     <= '0;
            h_reg     <= '0;
            c_reg     <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (seq_start) begin
                        remaining <= seq_len;
                        h_reg     <= '0;
                        c_reg     <= '0;
                        err_reg   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (x_valid) begin
                        x_reg <= x_in;
                    end
                end
                S_FIRE: begin
                    tcnt <= '0;
                end
                S_WAIT: begin
                    if (cell_done) begin
                        h_reg     <= cell_h;
                        c_reg     <= cell_c;
                        remaining <= remaining - LEN_W'(1);
                    end else if (timed_out) begin
                        err_reg <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TCW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign error       = err_reg;
    assign cell_x      = x_reg;
    assign cell_h_prev = h_reg;
    assign cell_c_prev = c_reg;
    assign h_out       = h_reg;

endmodule
